llr_dequant_stream: RTL and testbench

//  Inverse of the LLR group output quantizer. Accepts narrow normalized signed LLR groups plus
//  a per-group scale exponent over a valid/ready stream. Expands each element to a wider

---
 rtl/llr_dequant_stream.sv | 188 ++++++++++++++++++
 tb/tb_llr_dequant_stream.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/llr_dequant_stream.sv
// llr_dequant_stream
//   Expands narrow normalized signed LLR groups back to full-width LLRs.
//   Each element is sign-extended, shifted left by the per-group exponent,
//   then saturated to OUT_BIT bits. Two register stages sit behind a
//   valid/ready handshake, giving a throughput of one group per cycle.
//   Each beat is tagged with its group index within the frame.
//   Optional feature macro: LLR_DEQ_SAT_CNT_EN builds a saturation counter
//   on SAT_COUNT. Without the macro, SAT_COUNT is tied to zero.
module llr_dequant_stream #(
  parameter int IN_BIT    = 3,
  parameter int OUT_BIT   = 5,
  parameter int GROUP_NUM = 3,
  parameter int CNT_W     = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [GROUP_NUM*IN_BIT-1:0]  IN_LLR,
  input  logic [1:0]                   IN_SHIFT,
  input  logic                         IN_LAST,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [GROUP_NUM*OUT_BIT-1:0] OUT_LLR,
  output logic                         OUT_LAST,
  output logic [CNT_W-1:0]             OUT_GIDX,
  output logic [15:0]                  SAT_COUNT
);

  // Three guard bits hold the largest shift (3) of any IN_BIT value without overflow.
  localparam int EXT_W = OUT_BIT + 3;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((1 << (OUT_BIT - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [CNT_W-1:0] GIDX_MAX = '1;

  function automatic logic signed [EXT_W-1:0] expand_llr(input logic [IN_BIT-1:0] raw,
                                                        input logic [1:0] sh);
    logic signed [EXT_W-1:0] ext;
    ext = {{(EXT_W - IN_BIT){raw[IN_BIT-1]}}, raw};
    return ext <<< sh;
  endfunction

  function automatic logic sat_hit(input logic signed [EXT_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  // Clamp per element; values that already fit pass through bit-exact.
  function automatic logic signed [OUT_BIT-1:0] sat_llr(input logic signed [EXT_W-1:0] v);
    logic signed [OUT_BIT-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[OUT_BIT-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[OUT_BIT-1:0];
    end else begin
      r = v[OUT_BIT-1:0];
    end
    return r;
  endfunction

  logic                    adv_p1;
  logic                    adv_p2;
  logic                    accept;
  logic signed [EXT_W-1:0] e_p0 [GROUP_NUM];

  logic                    vld_p1;
  logic signed [EXT_W-1:0] e_p1 [GROUP_NUM];
  logic                    last_p1;
  logic [CNT_W-1:0]        gidx_p1;

  logic                    vld_p2;
  logic signed [OUT_BIT-1:0] llr_p2 [GROUP_NUM];
  logic                    last_p2;
  logic [CNT_W-1:0]        gidx_p2;

  logic [CNT_W-1:0]        gidx_cnt;

  // S2 drains when empty or taken downstream; S1 drains when empty or S2 moves.
  assign adv_p2   = !vld_p2 || OUT_READY;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign IN_READY = adv_p1;
  assign accept   = IN_VALID && adv_p1;

  // Sign-extend and shift every element of the incoming group.
  always_comb begin
    for (int i = 0; i < GROUP_NUM; i++) begin
      e_p0[i] = expand_llr(IN_LLR[i*IN_BIT +: IN_BIT], IN_SHIFT);
    end
  end

  // ---- stage S1: expanded elements, frame tags ----
  // Capture the expanded group when S1 can move; a cycle without accept empties it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      gidx_p1 <= '0;
      for (int i = 0; i < GROUP_NUM; i++) begin
        e_p1[i] <= '0;
      end
    end else if (adv_p1) begin
      vld_p1 <= accept;
      if (accept) begin
        last_p1 <= IN_LAST;
        gidx_p1 <= gidx_cnt;
        for (int i = 0; i < GROUP_NUM; i++) begin
          e_p1[i] <= e_p0[i];
        end
      end
    end
  end

  // ---- stage S2: saturated output elements ----
  // Saturate and register the S1 group when S2 can move; hold while stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      gidx_p2 <= '0;
      for (int i = 0; i < GROUP_NUM; i++) begin
        llr_p2[i] <= '0;
      end
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        last_p2 <= last_p1;
        gidx_p2 <= gidx_p1;
        for (int i = 0; i < GROUP_NUM; i++) begin
          llr_p2[i] <= sat_llr(e_p1[i]);
        end
      end
    end
  end

  // Group index within the frame: clears after the last group, sticks at all-ones.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gidx_cnt <= '0;
    end else if (accept) begin
      if (IN_LAST) begin
        gidx_cnt <= '0;
      end else if (gidx_cnt != GIDX_MAX) begin
        gidx_cnt <= gidx_cnt + 1'b1;
      end
    end
  end

  // Pack the S2 element array onto the output bus.
  always_comb begin
    OUT_LLR = '0;
    for (int i = 0; i < GROUP_NUM; i++) begin
      OUT_LLR[i*OUT_BIT +: OUT_BIT] = llr_p2[i];
    end
  end

  assign OUT_VALID = vld_p2;
  assign OUT_LAST  = last_p2;
  assign OUT_GIDX  = gidx_p2;

`ifdef LLR_DEQ_SAT_CNT_EN
  logic [15:0] sat_beat;
  logic [15:0] sat_cnt;
  logic [16:0] sat_sum;

  // Number of elements of the S1 group that will clip on their way into S2.
  always_comb begin
    sat_beat = '0;
    for (int i = 0; i < GROUP_NUM; i++) begin
      sat_beat = sat_beat + 16'(sat_hit(e_p1[i]));
    end
  end

  assign sat_sum = {1'b0, sat_cnt} + {1'b0, sat_beat};

  // Accumulate clipped elements once per group entering S2, pinned at full scale.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_cnt <= '0;
    end else if (adv_p2 && vld_p1) begin
      sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  assign SAT_COUNT = sat_cnt;
`else
  assign SAT_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_llr_dequant_stream.sv
// Directed bench for llr_dequant_stream (IN_BIT=3, OUT_BIT=5, GROUP_NUM=3, CNT_W=8).
// Inputs change on the falling edge; outputs are sampled 1 ns before the rising edge.
module tb_llr_dequant_stream;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [8:0]  IN_LLR = '0;
  logic [1:0]  IN_SHIFT = '0;
  logic        IN_LAST = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [14:0] OUT_LLR;
  logic        OUT_LAST;
  logic [7:0]  OUT_GIDX;
  logic [15:0] SAT_COUNT;

  llr_dequant_stream #(.IN_BIT(3), .OUT_BIT(5), .GROUP_NUM(3), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_LLR(IN_LLR), .IN_SHIFT(IN_SHIFT), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LLR(OUT_LLR),
    .OUT_LAST(OUT_LAST), .OUT_GIDX(OUT_GIDX), .SAT_COUNT(SAT_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int e2; int e1; int e0; int last; int gidx;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   sat_exp = 0;
  bit   saw_in_stall = 1'b0;
  bit   stalled = 1'b0;
  int   held_word = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int elem(input int i);
    logic signed [4:0] v;
    v = OUT_LLR[i*5 +: 5];
    return int'(v);
  endfunction

  // Present one beat and hold it until accepted; record the hand-computed result.
  task automatic send(input logic [2:0] a2, input logic [2:0] a1, input logic [2:0] a0,
                      input logic [1:0] sh, input logic lst,
                      input int x2, input int x1, input int x0, input int xg);
    exp_t x;
    int   n;
    n = 0;
    IN_VALID = 1'b1;
    IN_LLR   = {a2, a1, a0};
    IN_SHIFT = sh;
    IN_LAST  = lst;
    #4;
    while (!IN_READY && n < 50) begin
      @(negedge CLK);
      #4;
      n++;
    end
    if (!IN_READY) begin
      chk("send_timeout", 0, 1);
    end else begin
      x.e2 = x2; x.e1 = x1; x.e0 = x0; x.last = int'(lst); x.gidx = xg;
      exp_q.push_back(x);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic drain(input int cycles);
    repeat (cycles) @(negedge CLK);
  endtask

  // Output monitor: compare each transferred beat, and check hold during stalls.
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      if (RST) begin
        stalled = 1'b0;
      end else begin
        if (!IN_READY) saw_in_stall = 1'b1;
        if (OUT_VALID && OUT_READY) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("out_e2", elem(2), x.e2);
            chk("out_e1", elem(1), x.e1);
            chk("out_e0", elem(0), x.e0);
            chk("out_last", int'(OUT_LAST), x.last);
            chk("out_gidx", int'(OUT_GIDX), x.gidx);
          end
          stalled = 1'b0;
        end else if (OUT_VALID) begin
          if (stalled) chk("stall_stable", int'({OUT_LLR, OUT_LAST, OUT_GIDX}), held_word);
          held_word = int'({OUT_LLR, OUT_LAST, OUT_GIDX});
          stalled = 1'b1;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_out_llr", int'(OUT_LLR), 0);
    chk("rst_out_last", int'(OUT_LAST), 0);
    chk("rst_out_gidx", int'(OUT_GIDX), 0);
    chk("rst_sat_count", int'(SAT_COUNT), 0);
    RST = 1'b0;
    #1;
    chk("rst_in_ready", int'(IN_READY), 1);
    @(negedge CLK);

    // Test 1: {3,-3,0} << 2 -> {12,-12,0}, two cycles of latency
    send(3'b011, 3'b101, 3'b000, 2'd2, 1'b1, 12, -12, 0, 0);
    chk("t1_lat_s1", int'(OUT_VALID), 0);
    @(negedge CLK);
    #1;
    chk("t1_lat_out", int'(OUT_VALID), 1);
    drain(3);
    chk("t1_sat_count", int'(SAT_COUNT), sat_exp);

    // Test 2: saturation at both rails and exact-fit minimum
    send(3'b011, 3'b100, 3'b100, 2'd3, 1'b1, 15, -16, -16, 0);
    send(3'b100, 3'b100, 3'b100, 2'd2, 1'b1, -16, -16, -16, 0);
    send(3'b010, 3'b110, 3'b001, 2'd3, 1'b1, 15, -16, 8, 0);
`ifdef LLR_DEQ_SAT_CNT_EN
    sat_exp = 4;
`endif
    drain(4);
    chk("t2_sat_count", int'(SAT_COUNT), sat_exp);

    // Test 3: five back-to-back beats with OUT_READY low for three cycles
    saw_in_stall = 1'b0;
    fork
      begin
        send(3'b001, 3'b010, 3'b011, 2'd0, 1'b0, 1, 2, 3, 0);
        send(3'b111, 3'b110, 3'b101, 2'd0, 1'b0, -1, -2, -3, 1);
        send(3'b001, 3'b111, 3'b000, 2'd1, 1'b0, 2, -2, 0, 2);
        send(3'b011, 3'b000, 3'b101, 2'd1, 1'b0, 6, 0, -6, 3);
        send(3'b010, 3'b001, 3'b111, 2'd2, 1'b1, 8, 4, -4, 4);
      end
      begin
        @(negedge CLK);
        @(negedge CLK);
        OUT_READY = 1'b0;
        repeat (3) @(negedge CLK);
        OUT_READY = 1'b1;
      end
    join
    drain(4);
    chk("t3_in_ready_drop", int'(saw_in_stall), 1);
    chk("t3_all_out", exp_q.size(), 0);

    // Test 4: frame of four beats, then the start of the next frame
    send(3'b001, 3'b001, 3'b001, 2'd0, 1'b0, 1, 1, 1, 0);
    send(3'b010, 3'b010, 3'b010, 2'd0, 1'b0, 2, 2, 2, 1);
    send(3'b011, 3'b011, 3'b011, 2'd0, 1'b0, 3, 3, 3, 2);
    send(3'b100, 3'b100, 3'b100, 2'd0, 1'b1, -4, -4, -4, 3);
    send(3'b101, 3'b110, 3'b111, 2'd0, 1'b0, -3, -2, -1, 0);
    send(3'b000, 3'b001, 3'b010, 2'd0, 1'b0, 0, 1, 2, 1);
    drain(4);
    chk("t4_all_out", exp_q.size(), 0);
    chk("t4_sat_count", int'(SAT_COUNT), sat_exp);

    // Test 5: reset while two beats are stalled in the pipe
    OUT_READY = 1'b0;
    send(3'b001, 3'b001, 3'b001, 2'd1, 1'b0, 2, 2, 2, 2);
    send(3'b010, 3'b010, 3'b010, 2'd1, 1'b0, 4, 4, 4, 3);
    chk("t5_pipe_full", int'(IN_READY), 0);
    RST = 1'b1;
    #1;
    chk("t5_async_valid", int'(OUT_VALID), 0);
    chk("t5_async_gidx", int'(OUT_GIDX), 0);
    chk("t5_async_sat", int'(SAT_COUNT), 0);
    exp_q.delete();
    sat_exp = 0;
    @(negedge CLK);
    RST = 1'b0;
    OUT_READY = 1'b1;
    #1;
    chk("t5_in_ready", int'(IN_READY), 1);
    @(negedge CLK);
    send(3'b011, 3'b111, 3'b101, 2'd1, 1'b1, 6, -2, -6, 0);
    chk("t5_lat_s1", int'(OUT_VALID), 0);
    @(negedge CLK);
    #1;
    chk("t5_lat_out", int'(OUT_VALID), 1);
    drain(3);

    chk("final_drain", exp_q.size(), 0);
    chk("final_sat_count", int'(SAT_COUNT), sat_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
